alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the datapath's single-cycle ALU. Performs AND/OR/ADD/SUB/PassB plus logical shifts and an iterative multiply. Produces a full NZCV flag set. Sits between register read and writeback in the multi-cycle datapath; a valid/ready handshake lets the controller stall on multi-cycle ops.

## Interface
- N, default 64: operand/result width; power of two, 8..64.
- SHW, default $clog2(N): shift-amount width (derived, not overridden).
- CLK  in  1  clock, rising edge.
- ResetL  in  1  reset, asynchronous, active-low.
- InValid  in  1  operation request valid.
- InReady  out  1  block can accept a request this cycle.
- ALUCtrl  in  4  opcode, sampled on accept.
- BusA, BusB  in  N  operands, sampled on accept.
- OutValid  out  1  BusW/flags hold a completed result.
- OutReady  in  1  consumer takes the result this cycle.
- BusW  out  N  result register.
- Zero, Negative, Carry, Overflow  out  1 each  registered flags of BusW.

## Operation
- Opcodes: AND 0000, OR 0001, ADD 0010, LSL 0011, LSR 0100, SUB 0110, PassB 0111, MUL 1000.
- Any other opcode returns BusW=0 with Zero=1 and N/C/V=0, single-cycle.
- ADD/SUB are two's complement mod 2^N.
- ADD: Carry = carry-out.
- SUB: Carry = NOT borrow (BusA >= BusB unsigned).
- ADD/SUB: Overflow = signed overflow.
- LSL/LSR: amount = BusB[SHW-1:0]; upper BusB bits ignored; amount 0 returns BusA.
- MUL: low N bits of unsigned BusA*BusB, shift-add, one multiplier bit per cycle.
- Logic, shift, PassB, MUL: Carry=Overflow=0.
- All ops: Zero = (BusW==0); Negative = BusW[N-1].
- States: IDLE, BUSY, DONE.
  - IDLE: InReady=1. Accept (InValid&InReady): MUL -> BUSY with iteration counter=0; other op -> result registered, -> DONE.
  - BUSY: InReady=0; counter increments each cycle; after the N-th iteration latch result -> DONE.
  - DONE: OutValid=1; BusW and flags stable. If OutReady=0, stay.
  - DONE with OutReady=1 and no new accept -> IDLE.
  - DONE with OutReady=1 and a new accept -> treat as an accept from IDLE. Back-to-back single-cycle ops give one result per cycle.
- InReady = ResetL & (state==IDLE | (state==DONE & OutReady)). This is a combinational path from OutReady.
- Inputs are ignored when InReady=0. BusA/BusB/ALUCtrl need only be valid in the accept cycle.

## Timing
- Reset (ResetL low, any state including mid-MUL): immediately force IDLE, OutValid=0, BusW=0, Zero=0, Negative=0, Carry=0, Overflow=0, counter=0, InReady=0.
- First accept is possible on the first rising edge after ResetL rises.
- Single-cycle op accepted at edge k: OutValid=1 and result visible after edge k.
- MUL accepted at edge k: iterations at edges k+1..k+N; OutValid=1 after edge k+N. Latency is N cycles plus the accept edge.
- Result handoff occurs at the edge where OutValid&OutReady=1. BusW retains its last value after handoff until the next result is latched.
- OutReady while OutValid=0 has no effect.

## Structure
- Package alu_pkg holds:
  - opcode localparams (ALU_AND … ALU_MUL);
  - state encoding (S_IDLE=2'd0, S_BUSY=2'd1, S_DONE=2'd2);
  - the flag-vector ordering {N,Z,C,V}.
- Sub-module alu_mul_iter holds the N-bit shift-add multiplier: start, busy/done, product low half.
- Control FSM, combinational single-cycle unit and result/flag registers live in alu_seq.

## Test plan
- Reset mid-MUL: N=64, MUL 3*5 accepted, ResetL low at cycle 10 -> OutValid=0 and BusW=0 at once. After release, ADD 1+1 -> BusW=2, OutValid at next cycle.
- ADD overflow: N=8, ADD 0x7F+0x01 -> BusW=0x80, N=1, Z=0, C=0, V=1. ADD 0xFF+0x01 -> BusW=0, Z=1, C=1, V=0.
- SUB: N=64, SUB 5-5 -> Z=1, C=1. SUB 3-5 -> BusW=0xFFFF_FFFF_FFFF_FFFE, N=1, C=0.
- MUL: N=8, 0x0F*0x11 -> BusW=0xFF, OutValid exactly 8 cycles after accept, InReady=0 throughout BUSY. 0x10*0x10 -> BusW=0x00, Z=1.
- Shifts: N=64, LSL 1 by BusB=0x41 -> amount 1, BusW=2. LSR 0x8000_0000_0000_0000 by 63 -> BusW=1.
- Backpressure/streaming: hold OutReady=0 for 5 cycles after an OR result -> BusW stable, InReady=0. Then OutReady=1 with 4 back-to-back PassB ops -> 4 results on 4 consecutive edges. Also: illegal opcode 1111 -> BusW=0, Z=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, control states, flag bit positions.
// No logic; imported by alu_seq and alu_mul_iter.
// Flag vector is packed {N,Z,C,V} with N in the MSB.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_LSL  = 4'b0011;
    localparam logic [3:0] ALU_LSR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [3:0] ALU_MUL  = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier, low N bits of unsigned a*b, one multiplier bit per cycle.
// Latency: N cycles after the start edge; done is high during the final iteration cycle.
// No backpressure: the caller must latch prod in the cycle done is asserted.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         CLK,
    input  logic         ResetL,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] prod
);

    localparam int SHW = $clog2(N);
    localparam logic [SHW-1:0] LAST = SHW'(N - 1);

    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [N-1:0]   partial;

    // prod includes the current iteration so the caller can latch it on the last edge
    assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod    = partial;
    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == LAST);

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: AND/OR/ADD/SUB/PassB/LSL/LSR single-cycle, MUL iterative; registered NZCV.
// Latency: result after the accept edge; MUL adds N iteration edges.
// Holds the result while OutReady=0; InReady is combinational from OutReady when DONE.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         CLK,
    input  logic         ResetL,
    input  logic         InValid,
    output logic         InReady,
    input  logic [3:0]   ALUCtrl,
    input  logic [N-1:0] BusA,
    input  logic [N-1:0] BusB,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [N-1:0] BusW,
    output logic         Zero,
    output logic         Negative,
    output logic         Carry,
    output logic         Overflow
);

    localparam int SHW = $clog2(N);

    state_t       state_q, state_d;
    logic [N-1:0] busw_q, busw_d;
    logic [3:0]   flags_q, flags_d;

    logic         accept;
    logic         mul_start, mul_busy, mul_done;
    logic [N-1:0] mul_prod;
    logic [N-1:0] sc_res;
    logic         sc_c, sc_v;
    logic [N:0]   sum_add, sum_sub;

    assign InReady  = ResetL && ((state_q == S_IDLE) || ((state_q == S_DONE) && OutReady));
    assign accept   = InValid && InReady;
    assign OutValid = (state_q == S_DONE);
    assign BusW     = busw_q;
    assign Negative = flags_q[FLAG_N];
    assign Zero     = flags_q[FLAG_Z];
    assign Carry    = flags_q[FLAG_C];
    assign Overflow = flags_q[FLAG_V];

    // SUB as A + ~B + 1, so the carry-out is already NOT borrow
    assign sum_add = {1'b0, BusA} + {1'b0, BusB};
    assign sum_sub = {1'b0, BusA} + {1'b0, ~BusB} + (N+1)'(1);

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (ALUCtrl)
            ALU_AND:  sc_res = BusA & BusB;
            ALU_OR:   sc_res = BusA | BusB;
            ALU_ADD: begin
                sc_res = sum_add[N-1:0];
                sc_c   = sum_add[N];
                sc_v   = (BusA[N-1] == BusB[N-1]) && (sc_res[N-1] != BusA[N-1]);
            end
            ALU_SUB: begin
                sc_res = sum_sub[N-1:0];
                sc_c   = sum_sub[N];
                sc_v   = (BusA[N-1] != BusB[N-1]) && (sc_res[N-1] != BusA[N-1]);
            end
            ALU_LSL:  sc_res = BusA << BusB[SHW-1:0];
            ALU_LSR:  sc_res = BusA >> BusB[SHW-1:0];
            ALU_PASS: sc_res = BusB;
            default:  sc_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        busw_d    = busw_q;
        flags_d   = flags_q;
        mul_start = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE && OutReady) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
                    if (ALUCtrl == ALU_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_BUSY;
                    end else begin
                        busw_d  = sc_res;
                        flags_d = {sc_res[N-1], (sc_res == '0), sc_c, sc_v};
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (mul_done) begin
                    busw_d  = mul_prod;
                    flags_d = {mul_prod[N-1], (mul_prod == '0), 1'b0, 1'b0};
                    state_d = S_DONE;
                end else if (!mul_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            state_q <= S_IDLE;
            busw_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            busw_q  <= busw_d;
            flags_q <= flags_d;
        end
    end

    alu_mul_iter #(.N(N)) u_mul (
        .CLK    (CLK),
        .ResetL (ResetL),
        .start  (mul_start),
        .a      (BusA),
        .b      (BusB),
        .busy   (mul_busy),
        .done   (mul_done),
        .prod   (mul_prod)
    );

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        bit          sel;   // 0: N=64 instance, 1: N=8 instance
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] w;
        logic [3:0]  f;     // {N,Z,C,V}
    } vec_t;

    typedef struct {
        logic [63:0] w;
        logic [3:0]  f;
    } exp_t;

    logic        CLK = 1'b0;
    logic        ResetL = 1'b0;
    logic        v64 = 1'b0, v8 = 1'b0;
    logic        OutReady = 1'b1;
    logic [3:0]  op_s = 4'd0;
    logic [63:0] ba = '0, bb = '0;

    logic        ir64, ov64, z64, n64, c64, o64;
    logic [63:0] w64;
    logic        ir8, ov8, z8, n8, c8, o8;
    logic [7:0]  w8;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    exp_t q64[$];
    exp_t q8[$];
    exp_t e64, e8;
    int   hq[$];
    vec_t vt[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    alu_seq #(.N(64)) dut64 (
        .CLK(CLK), .ResetL(ResetL), .InValid(v64), .InReady(ir64), .ALUCtrl(op_s),
        .BusA(ba), .BusB(bb), .OutValid(ov64), .OutReady(OutReady), .BusW(w64),
        .Zero(z64), .Negative(n64), .Carry(c64), .Overflow(o64)
    );

    alu_seq #(.N(8)) dut8 (
        .CLK(CLK), .ResetL(ResetL), .InValid(v8), .InReady(ir8), .ALUCtrl(op_s),
        .BusA(ba[7:0]), .BusB(bb[7:0]), .OutValid(ov8), .OutReady(OutReady), .BusW(w8),
        .Zero(z8), .Negative(n8), .Carry(c8), .Overflow(o8)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        total_cnt++;
        if (got !== expv)
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        else
            pass_cnt++;
    endtask

    // Result handoffs are scored at the negedge before the edge that completes them.
    always @(negedge CLK) begin
        if (ResetL && OutReady && ov64) begin
            hq.push_back(cyc);
            if (q64.size() == 0) begin
                check("unexpected_result64", 64'd1, 64'd0);
            end else begin
                e64 = q64.pop_front();
                check("busw64", w64, e64.w);
                check("flags64", {60'd0, n64, z64, c64, o64}, {60'd0, e64.f});
            end
        end
        if (ResetL && OutReady && ov8) begin
            if (q8.size() == 0) begin
                check("unexpected_result8", 64'd1, 64'd0);
            end else begin
                e8 = q8.pop_front();
                check("busw8", {56'd0, w8}, e8.w);
                check("flags8", {60'd0, n8, z8, c8, o8}, {60'd0, e8.f});
            end
        end
    end

    // Called and returns at posedge+2; returns just after the accept edge.
    task automatic issue(input bit sel, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] w, input logic [3:0] f);
        bit   acc;
        exp_t e;
        acc  = 1'b0;
        op_s = op;
        ba   = a;
        bb   = b;
        if (sel) v8 = 1'b1; else v64 = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge CLK);
            acc = sel ? ir8 : ir64;
            @(posedge CLK);
            #2;
        end
        v8  = 1'b0;
        v64 = 1'b0;
        if (!acc) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            e.w = w;
            e.f = f;
            if (sel) q8.push_back(e); else q64.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q64.size() != 0 || q8.size() != 0); i++) begin
            @(posedge CLK);
            #2;
        end
        if (q64.size() != 0 || q8.size() != 0) begin
            check("drain_timeout", 64'd0, 64'd1);
            q64.delete();
            q8.delete();
        end
    endtask

    initial begin
        int bad;
        vt.push_back('{1, ALU_ADD,  64'h7F, 64'h01, 64'h80, 4'b1001});
        vt.push_back('{1, ALU_ADD,  64'hFF, 64'h01, 64'h00, 4'b0110});
        vt.push_back('{1, ALU_SUB,  64'h80, 64'h01, 64'h7F, 4'b0011});
        vt.push_back('{1, ALU_MUL,  64'h0F, 64'h11, 64'hFF, 4'b1000});
        vt.push_back('{1, ALU_MUL,  64'h10, 64'h10, 64'h00, 4'b0100});
        vt.push_back('{1, ALU_AND,  64'hF0, 64'h3C, 64'h30, 4'b0000});
        vt.push_back('{1, ALU_LSL,  64'h81, 64'h0F, 64'h80, 4'b1000});
        vt.push_back('{1, ALU_LSR,  64'h80, 64'h09, 64'h40, 4'b0000});
        vt.push_back('{1, 4'b0101,  64'h12, 64'h34, 64'h00, 4'b0100});
        vt.push_back('{0, ALU_SUB,  64'd5, 64'd5, 64'd0, 4'b0110});
        vt.push_back('{0, ALU_SUB,  64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000});
        vt.push_back('{0, ALU_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110});
        vt.push_back('{0, ALU_LSL,  64'd1, 64'h41, 64'd2, 4'b0000});
        vt.push_back('{0, ALU_LSR,  64'h8000_0000_0000_0000, 64'd63, 64'd1, 4'b0000});
        vt.push_back('{0, ALU_LSR,  64'h1234, 64'h40, 64'h1234, 4'b0000});
        vt.push_back('{0, ALU_PASS, 64'h55, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 4'b1000});
        vt.push_back('{0, 4'b1111,  64'hAB, 64'hCD, 64'd0, 4'b0100});
        vt.push_back('{0, ALU_MUL,  64'hFFFF_FFFF, 64'd3, 64'h2_FFFF_FFFD, 4'b0000});

        repeat (3) @(posedge CLK);
        #2;
        check("reset_outvalid", {62'd0, ov64, ov8}, 64'd0);
        check("reset_inready",  {62'd0, ir64, ir8}, 64'd0);
        check("reset_busw",     w64 | {56'd0, w8}, 64'd0);
        check("reset_flags",    {56'd0, n64, z64, c64, o64, n8, z8, c8, o8}, 64'd0);
        ResetL = 1'b1;

        foreach (vt[i]) begin
            issue(vt[i].sel, vt[i].op, vt[i].a, vt[i].b, vt[i].w, vt[i].f);
            drain();
        end

        // MUL latency: OutValid exactly 8 edges after accept, InReady low while busy
        issue(1, ALU_MUL, 64'h0F, 64'h11, 64'hFF, 4'b1000);
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge CLK);
            #2;
            if (i < 8 && (ov8 || ir8)) bad++;
            if (i == 8) check("mul8_outvalid_at_n", {63'd0, ov8}, 64'd1);
        end
        check("mul8_busy_cycles", 64'(bad), 64'd0);
        drain();

        // Reset in the middle of a MUL
        issue(0, ALU_ADD, 64'd7, 64'd0, 64'd7, 4'b0000);
        drain();
        issue(0, ALU_MUL, 64'd3, 64'd5, 64'd15, 4'b0000);
        repeat (8) @(posedge CLK);
        #2;
        check("busw_kept_while_busy", w64, 64'd7);
        ResetL = 1'b0;
        #1;
        check("midmul_reset_outvalid", {63'd0, ov64}, 64'd0);
        check("midmul_reset_busw", w64, 64'd0);
        check("midmul_reset_inready", {63'd0, ir64}, 64'd0);
        q64.delete();
        @(posedge CLK);
        #2;
        ResetL = 1'b1;
        issue(0, ALU_ADD, 64'd1, 64'd1, 64'd2, 4'b0000);
        check("add_after_reset_outvalid", {63'd0, ov64}, 64'd1);
        drain();

        // Backpressure then streaming
        OutReady = 1'b0;
        issue(0, ALU_OR, 64'hF0F0, 64'h0F0F, 64'hFFFF, 4'b0000);
        bad = 0;
        repeat (5) begin
            @(posedge CLK);
            #2;
            if (w64 !== 64'hFFFF || ov64 !== 1'b1 || ir64 !== 1'b0) bad++;
        end
        check("stall_hold", 64'(bad), 64'd0);
        hq.delete();
        OutReady = 1'b1;
        for (int k = 1; k <= 4; k++)
            issue(0, ALU_PASS, 64'd0, 64'(k), 64'(k), 4'b0000);
        drain();
        check("stream_count", 64'(hq.size()), 64'd5);
        if (hq.size() == 5)
            check("stream_span", 64'(hq[4] - hq[0]), 64'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
